// File: rtl/conv_mem_responder.sv
// Memory-side responder for the convolution accelerator: image and layer banks.
// Optional write counter on wr_cnt enabled by CONV_MEM_ACCCNT_EN.
module conv_mem_responder #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  output logic          ready,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [2:0]    csel,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          img_we,
  input  logic [AW-1:0] img_waddr,
  input  logic [DW-1:0] img_wdata,
  output logic          done,
  output logic          err,
  output logic [12:0]   wr_cnt
);

  localparam int L0_AW = $clog2(L0_DEPTH);
  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int L2_AW = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {
    IDLE, READY, RUN, DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] image [1<<AW];
  logic [DW-1:0] mem1  [L0_DEPTH];
  logic [DW-1:0] mem2  [L0_DEPTH];
  logic [DW-1:0] mem3  [L1_DEPTH];
  logic [DW-1:0] mem4  [L1_DEPTH];
  logic [DW-1:0] mem5  [L2_DEPTH];

  logic          run;
  logic          img_ok;
  logic          wr_ok;
  logic          rd_ok;
  logic          bad;
  logic [DW-1:0] rd_word;

  function automatic logic in_range(
    input logic [2:0]    sel,
    input logic [AW-1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (sel)
      3'd1, 3'd2: ok = int'(a) < L0_DEPTH;
      3'd3, 3'd4: ok = int'(a) < L1_DEPTH;
      3'd5:       ok = int'(a) < L2_DEPTH;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // READY always lasts a cycle, even if busy is already high
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = READY;
      READY:   if (busy) state_nx = RUN;
      RUN:     if (!busy) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready  = state == READY;
  assign done   = state == DONE;
  assign run    = state == RUN;
  assign img_ok = state == IDLE || state == READY;
  assign wr_ok  = run && cwr && in_range(csel, caddr_wr);
  assign rd_ok  = run && crd && in_range(csel, caddr_rd);
  assign bad    = (cwr && !wr_ok) || (crd && !rd_ok)
               || (img_we && !img_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   err <= 1'b0;
    else if (bad) err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (img_we && img_ok) image[img_waddr] <= img_wdata;
    if (wr_ok) begin
      unique case (csel)
        3'd1:    mem1[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd2:    mem2[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd3:    mem3[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd4:    mem4[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd5:    mem5[caddr_wr[L2_AW-1:0]] <= cdata_wr;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (csel)
      3'd1:    rd_word = mem1[caddr_rd[L0_AW-1:0]];
      3'd2:    rd_word = mem2[caddr_rd[L0_AW-1:0]];
      3'd3:    rd_word = mem3[caddr_rd[L1_AW-1:0]];
      3'd4:    rd_word = mem4[caddr_rd[L1_AW-1:0]];
      3'd5:    rd_word = mem5[caddr_rd[L2_AW-1:0]];
      default: rd_word = '0;
    endcase
  end

  // Falling-edge reads see the array before the next posedge write
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      idata    <= '0;
      cdata_rd <= '0;
    end else begin
      if (state == READY || run) idata <= image[iaddr];
      if (crd) cdata_rd <= rd_ok ? rd_word : '0;
    end
  end

`ifdef CONV_MEM_ACCCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       wr_cnt <= '0;
    else if (wr_ok && wr_cnt != '1)   wr_cnt <= wr_cnt + 13'd1;
  end
`else
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed + randomized bench for conv_mem_responder.
// Expected values come from associative-array memory models.
module tb_conv_mem_responder;

  logic        clk = 1'b0;
  logic        reset, busy;
  logic        ready, done, err;
  logic [11:0] iaddr, caddr_wr, caddr_rd, img_waddr;
  logic [19:0] idata, cdata_wr, cdata_rd, img_wdata;
  logic [2:0]  csel;
  logic        cwr, crd, img_we;
  logic [12:0] wr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] img_m [int];
  logic [19:0] lay_m [int];
  bit          run_m, err_m;
  int          cnt_m;
  logic [19:0] rd_m;
  int          wq [$];

`ifdef CONV_MEM_ACCCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  conv_mem_responder dut (
    .clk(clk), .reset(reset), .busy(busy), .ready(ready),
    .iaddr(iaddr), .idata(idata), .csel(csel), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .img_we(img_we),
    .img_waddr(img_waddr), .img_wdata(img_wdata), .done(done),
    .err(err), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int depth(int s);
    case (s)
      1, 2:    return 4096;
      3, 4:    return 1024;
      5:       return 2048;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(int s, int a);
    return run_m && a < depth(s);
  endfunction

  task automatic img_wr(int a, logic [19:0] d);
    img_we = 1'b1;
    img_waddr = 12'(a);
    img_wdata = d;
    cyc();
    img_we = 1'b0;
    if (run_m || done) err_m = 1'b1;
    else img_m[a] = d;
    chk("img_err", {31'd0, err}, {31'd0, err_m});
  endtask

  task automatic img_rd(int a);
    iaddr = 12'(a);
    @(negedge clk);
    #1;
    chk("idata", {12'd0, idata}, {12'd0, img_m[a]});
  endtask

  task automatic acc(bit w, int s, int aw, logic [19:0] d,
                     bit r, int ar);
    cwr = w;
    csel = 3'(s);
    caddr_wr = 12'(aw);
    cdata_wr = d;
    crd = r;
    caddr_rd = 12'(ar);
    if (r) rd_m = legal(s, ar) ? lay_m[s*4096+ar] : 20'h0;
    @(negedge clk);
    #1;
    chk("cdata_rd", {12'd0, cdata_rd}, {12'd0, rd_m});
    cyc();
    if (w && legal(s, aw)) begin
      lay_m[s*4096+aw] = d;
      if (cnt_m < 8191) cnt_m++;
    end
    if ((w && !legal(s, aw)) || (r && !legal(s, ar))) err_m = 1'b1;
    cwr = 1'b0;
    crd = 1'b0;
    chk("err", {31'd0, err}, {31'd0, err_m});
  endtask

  task automatic chk_rst();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_idata", {12'd0, idata}, 32'd0);
    chk("rst_cdata", {12'd0, cdata_rd}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wrcnt", {19'd0, wr_cnt}, 32'd0);
  endtask

  initial begin
    int s, a;
    reset = 1'b0; busy = 1'b0;
    iaddr = '0; caddr_wr = '0; caddr_rd = '0; img_waddr = '0;
    cdata_wr = '0; img_wdata = '0; csel = '0;
    cwr = 1'b0; crd = 1'b0; img_we = 1'b0;
    run_m = 1'b0; err_m = 1'b0; cnt_m = 0; rd_m = '0;

    #12;
    chk_rst();
    reset = 1'b1;
    #1;
    chk("ready_idle", {31'd0, ready}, 32'd0);
    cyc();
    chk("ready_up", {31'd0, ready}, 32'd1);

    img_wr(5, 20'h00ABC);
    for (int i = 0; i < 6; i++)
      img_wr($urandom_range(6, 4095), 20'($urandom));
    img_rd(5);

    busy = 1'b1;
    cyc();
    run_m = 1'b1;
    chk("ready_drop", {31'd0, ready}, 32'd0);
    foreach (img_m[k]) img_rd(k);

    acc(1, 1, 100, 20'h12345, 0, 0);
    acc(1, 2, 100, 20'($urandom), 1, 100);
    acc(0, 1, 0, 20'h0, 1, 100);
    acc(0, 2, 0, 20'h0, 1, 100);
    acc(1, 3, 7, 20'h00022, 0, 0);
    acc(1, 3, 7, 20'h00011, 1, 7);
    acc(0, 3, 0, 20'h0, 1, 7);
    acc(1, 3, 0, 20'($urandom), 0, 0);
    acc(1, 5, 0, 20'($urandom), 0, 0);
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(1, 5);
      a = $urandom_range(0, depth(s) - 1);
      wq.push_back(s * 4096 + a);
      acc(1, s, a, 20'($urandom), 0, 0);
    end
    foreach (wq[i]) acc(0, wq[i] / 4096, 0, 20'h0, 1, wq[i] % 4096);
    acc(0, 1, 0, 20'h0, 0, 0);

    acc(0, 6, 0, 20'h0, 1, 0);
    acc(1, 3, 1024, 20'hFFFFF, 0, 0);
    acc(1, 5, 2048, 20'hFFFFF, 0, 0);
    acc(1, 0, 5, 20'hFFFFF, 0, 0);
    acc(0, 3, 0, 20'h0, 1, 0);
    acc(0, 5, 0, 20'h0, 1, 0);
    img_wr(5, 20'hFFFFF);
    img_rd(5);

    busy = 1'b0;
    cyc();
    run_m = 1'b0;
    chk("done_set", {31'd0, done}, 32'd1);
    chk("ready_done", {31'd0, ready}, 32'd0);
    repeat (3) cyc();
    chk("done_hold", {31'd0, done}, 32'd1);
    chk("wr_cnt", {19'd0, wr_cnt}, CNT_EN ? 32'(cnt_m) : 32'd0);
    acc(1, 1, 100, 20'hFFFFF, 0, 0);

    reset = 1'b0;
    #2;
    chk_rst();
    @(negedge clk);
    #1;
    reset = 1'b1;
    err_m = 1'b0; cnt_m = 0; rd_m = '0;
    cyc();
    chk("ready_2", {31'd0, ready}, 32'd1);
    busy = 1'b1;
    cyc();
    run_m = 1'b1;
    acc(0, 1, 0, 20'h0, 1, 100);
    #2;
    reset = 1'b0;
    #1;
    chk_rst();
    run_m = 1'b0;
    rd_m = '0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    cyc();
    chk("ready_busy", {31'd0, ready}, 32'd1);
    cyc();
    chk("run_busy", {31'd0, ready}, 32'd0);
    run_m = 1'b1;
    foreach (lay_m[k]) acc(0, k / 4096, 0, 20'h0, 1, k % 4096);
    busy = 1'b0;
    cyc();
    chk("done_2", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
